// File: rtl/hamming_pkg.sv
// Shared constants, types and helpers for the Hamming frame encoder.
// Build option: define HAMMING_SECDED_EN for 8-bit SECDED codewords.
package hamming_pkg;

  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'b0111_1110;

`ifdef HAMMING_SECDED_EN
  localparam int CW = 8;
`else
  localparam int CW = 7;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } out_state_e;

  function automatic int frame_bits(input int data_bits, input int sync_bits);
    return sync_bits + (data_bits / 4) * CW;
  endfunction

endpackage

// File: rtl/hamming_nibble_encoder.sv
// Combinational Hamming(7,4) nibble encoder; HAMMING_SECDED_EN appends
// an even overall-parity bit to form an 8-bit SECDED codeword.
module hamming_nibble_encoder
  import hamming_pkg::*;
(
  input  logic [3:0]    d,
  output logic [CW-1:0] cw
);

  logic [6:0] ham;

  assign ham[0] = d[0] ^ d[1] ^ d[3];
  assign ham[1] = d[0] ^ d[2] ^ d[3];
  assign ham[2] = d[0];
  assign ham[3] = d[1] ^ d[2] ^ d[3];
  assign ham[4] = d[1];
  assign ham[5] = d[2];
  assign ham[6] = d[3];

`ifdef HAMMING_SECDED_EN
  assign cw = {^ham, ham};
`else
  assign cw = ham;
`endif

endmodule

// File: rtl/hamming_frame_encoder.sv
// Serial-in Hamming frame encoder: assembles DATA_BITS, encodes per nibble,
// prefixes SYNC_WORD and serialises MSB-first. Option: HAMMING_SECDED_EN.
module hamming_frame_encoder
  import hamming_pkg::*;
#(
  parameter int                   DATA_BITS = 32,
  parameter int                   SYNC_BITS = 8,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD = DEFAULT_SYNC_WORD,
  parameter int                   CNT_W     = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             data_in,
  input  logic             data_valid,
  output logic             data_in_ready,
  output logic             data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic             data_out_sof,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int NIB        = DATA_BITS / 4;
  localparam int FRAME_BITS = frame_bits(DATA_BITS, SYNC_BITS);
  localparam int IDX_W      = $clog2(FRAME_BITS);
  localparam int BIT_W      = ($clog2(DATA_BITS) + 1 > 6) ? $clog2(DATA_BITS) + 1 : 6;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

  if ((DATA_BITS < 4) || (DATA_BITS % 4 != 0)) begin : g_bad_data_bits
    $error("DATA_BITS must be a positive multiple of 4");
  end
  if (SYNC_BITS < 1) begin : g_bad_sync_bits
    $error("SYNC_BITS must be at least 1");
  end

  logic [DATA_BITS-1:0]  asm_q, asm_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  full_q, full_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  out_state_e            state_q, state_d;
  logic [CNT_W-1:0]      frames_sent_q, frames_sent_d;

  logic                  in_fire;
  logic                  out_fire;
  logic                  last_fire;
  logic                  load;
  logic [NIB*CW-1:0]     enc_w;

  for (genvar k = 0; k < NIB; k++) begin : g_nib
    hamming_nibble_encoder u_enc (
      .d  (asm_q[4*k +: 4]),
      .cw (enc_w[CW*k +: CW])
    );
  end

  // A pending frame loads when the line is idle or as its predecessor's last bit leaves.
  always_comb begin
    in_fire   = data_valid && !full_q;
    out_fire  = (state_q == SEND) && data_out_ready;
    last_fire = out_fire && (idx_q == IDX_LAST);
    load      = full_q && ((state_q == IDLE) || last_fire);
  end

  // NOTE: every signal written here gets a default first; a path that skips an assignment would infer a latch.
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    full_d        = full_q;
    state_d       = state_q;
    idx_d         = idx_q;
    frames_sent_d = frames_sent_q;

    if (in_fire) begin
      if (bit_cnt_q == BIT_LAST) begin
        bit_cnt_d = '0;
        full_d    = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    if (last_fire) begin
      frames_sent_d = frames_sent_q + 1'b1;
    end

    if (load) begin
      full_d  = 1'b0;
      idx_d   = '0;
      state_d = SEND;
    end else if (out_fire) begin
      if (last_fire) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // First accepted bit shifts up to data[DATA_BITS-1]; the frame shifts out MSB-first.
  always_comb begin
    asm_d   = asm_q;
    frame_d = frame_q;

    if (in_fire) begin
      asm_d = {asm_q[DATA_BITS-2:0], data_in};
    end

    if (load) begin
      frame_d = {SYNC_WORD, enc_w};
    end else if (out_fire) begin
      frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      bit_cnt_q     <= '0;
      full_q        <= 1'b0;
      state_q       <= IDLE;
      idx_q         <= '0;
      frames_sent_q <= '0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      full_q        <= full_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  // NOTE: payload registers are not reset; full_q and state_q qualify their contents.
  always_ff @(posedge clk_in) begin
    asm_q   <= asm_d;
    frame_q <= frame_d;
  end

  assign data_in_ready  = !full_q;
  assign data_out_valid = (state_q == SEND);
  assign data_out       = data_out_valid && frame_q[FRAME_BITS-1];
  assign data_out_sof   = data_out_valid && (idx_q == '0);
  assign frames_sent    = frames_sent_q;

endmodule

// File: tb/tb_hamming_frame_encoder.sv
// Scoreboard bench for hamming_frame_encoder: random handshakes on both sides,
// expected frames built from the positional Hamming rule and popped by a monitor.
module tb_hamming_frame_encoder;

  localparam int DATA_BITS = 32;
  localparam int SYNC_BITS = 8;
  localparam int CNT_W     = 16;
  localparam logic [SYNC_BITS-1:0] TB_SYNC = 8'b0111_1110;
`ifdef HAMMING_SECDED_EN
  localparam int TB_CW = 8;
`else
  localparam int TB_CW = 7;
`endif
  localparam int NIB        = DATA_BITS / 4;
  localparam int FRAME_BITS = SYNC_BITS + NIB * TB_CW;

  logic             clk_in;
  logic             rst;
  logic             data_in;
  logic             data_valid;
  logic             data_in_ready;
  logic             data_out;
  logic             data_out_valid;
  logic             data_out_ready;
  logic             data_out_sof;
  logic [CNT_W-1:0] frames_sent;

  hamming_frame_encoder #(
    .DATA_BITS (DATA_BITS),
    .SYNC_BITS (SYNC_BITS),
    .SYNC_WORD (TB_SYNC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_sof   (data_out_sof),
    .frames_sent    (frames_sent)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic b;
    logic sof;
  } exp_t;

  exp_t exp_q[$];

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Classic positional Hamming: data at positions 3,5,6,7; parity p covers positions with bit p set.
  function automatic logic [7:0] ref_code(input logic [3:0] d);
    int         data_pos [4];
    logic [7:0] c;
    logic       par;
    data_pos = '{3, 5, 6, 7};
    c = '0;
    for (int i = 0; i < 4; i++) c[data_pos[i]-1] = d[i];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int q = 1; q <= 7; q++) begin
        if (((q & p) != 0) && (q != p)) par = par ^ c[q-1];
      end
      c[p-1] = par;
    end
    c[7] = ^c[6:0];
    return c;
  endfunction

  task automatic push_frame(input logic [DATA_BITS-1:0] w);
    logic [7:0] code;
    exp_t       e;
    for (int i = SYNC_BITS - 1; i >= 0; i--) begin
      e.b   = TB_SYNC[i];
      e.sof = (i == SYNC_BITS - 1);
      exp_q.push_back(e);
    end
    for (int k = NIB - 1; k >= 0; k--) begin
      code = ref_code(w[4*k +: 4]);
      for (int j = TB_CW - 1; j >= 0; j--) begin
        e.b   = code[j];
        e.sof = 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  // Protocol-level model of the encoder, advanced once per cycle.
  logic [DATA_BITS-1:0] m_word;
  int                   m_cnt;
  logic                 m_full;
  logic                 m_sending;
  int                   m_left;
  logic [CNT_W-1:0]     m_frames;
  logic                 armed      = 1'b0;
  logic                 just_reset = 1'b0;

  always @(negedge clk_in) begin
    logic accept, out_hs, last, load;
    if (armed) begin
      check("in_ready", 64'(data_in_ready), 64'(!m_full));
      check("out_valid", 64'(data_out_valid), 64'(m_sending));
      check("frames_sent", 64'(frames_sent), 64'(m_frames));
      if (just_reset) begin
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_sof", 64'(data_out_sof), 64'd0);
      end
      if (data_out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(data_out_valid), 64'd0);
        end else begin
          check("data_out", 64'(data_out), 64'(exp_q[0].b));
          check("sof", 64'(data_out_sof), 64'(exp_q[0].sof));
          if (data_out_ready) void'(exp_q.pop_front());
        end
      end
    end
    just_reset = 1'b0;

    if (rst) begin
      m_word     = '0;
      m_cnt      = 0;
      m_full     = 1'b0;
      m_sending  = 1'b0;
      m_left     = 0;
      m_frames   = '0;
      exp_q.delete();
      armed      = 1'b1;
      just_reset = 1'b1;
    end else if (armed) begin
      accept = data_valid && !m_full;
      out_hs = m_sending && data_out_ready;
      last   = out_hs && (m_left == 1);
      load   = m_full && (!m_sending || last);
      if (accept) begin
        m_word[DATA_BITS-1-m_cnt] = data_in;
        m_cnt++;
        if (m_cnt == DATA_BITS) begin
          m_full = 1'b1;
          m_cnt  = 0;
          push_frame(m_word);
        end
      end
      if (last) m_frames = m_frames + 1'b1;
      if (load) begin
        m_full    = 1'b0;
        m_sending = 1'b1;
        m_left    = FRAME_BITS;
      end else if (out_hs) begin
        m_left--;
        if (m_left == 0) m_sending = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    data_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drive_word(input logic [DATA_BITS-1:0] w);
    int   waited;
    logic acc;
    for (int i = DATA_BITS - 1; i >= 0; i--) begin
      waited     = 0;
      acc        = 1'b0;
      data_valid = 1'b1;
      data_in    = w[i];
      while (!acc && waited < 500) begin
        @(negedge clk_in);
        acc = data_in_ready;
        step();
        waited++;
      end
      if (!acc) check("drive_timeout", 64'(data_in_ready), 64'd1);
    end
    data_valid = 1'b0;
  endtask

  task automatic random_phase(input int n, input int valid_pct, input int ready_pct);
    repeat (n) begin
      data_valid     = ($urandom_range(99) < valid_pct);
      data_in        = 1'($urandom);
      data_out_ready = ($urandom_range(99) < ready_pct);
      step();
    end
  endtask

  initial begin
    rst            = 1'b1;
    data_in        = 1'b0;
    data_valid     = 1'b0;
    data_out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    data_out_ready = 1'b1;
    drive_word('1);
    idle(FRAME_BITS + 8);
    check("all_ones_frames", 64'(frames_sent), 64'd1);

    drive_word(DATA_BITS'(1));
    idle(FRAME_BITS + 8);
    check("one_hot_frames", 64'(frames_sent), 64'd2);

    random_phase(400, 100, 100);
    random_phase(1500, 60, 50);
    random_phase(600, 100, 25);

    random_phase(45, 100, 100);
    rst        = 1'b1;
    data_valid = 1'b1;
    step();
    rst = 1'b0;
    random_phase(400, 80, 70);

    data_out_ready = 1'b1;
    idle(3 * FRAME_BITS);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
